// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if: requester and RAM-side signals of the two-port memory arbiter.
interface main_memory_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic [15:0]       conflict_count;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata,
        input  m1_address, m1_read, m1_write, m1_writedata,
        input  mem_readdata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_chipselect, mem_write, mem_clken, mem_writedata,
        output conflict_count
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata,
        output m1_address, m1_read, m1_write, m1_writedata,
        output mem_readdata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_chipselect, mem_write, mem_clken, mem_writedata,
        input  conflict_count
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: round-robin sharing of one single-port RAM between two requesters,
// combinational grant, 1-clock read return routed by a registered tag.
module main_memory_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    main_memory_arbiter_if.slave bus
);
    logic              act0, act1, gnt0, gnt1, gnt, gnt_wr;
    logic              rr_ptr_d, rr_ptr_q;
    logic              rtn_vld_d, rtn_vld_q, rtn_id_d, rtn_id_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic [15:0]       conflict_d, conflict_q;

    always_comb begin
        act0       = bus.m0_read | bus.m0_write;
        act1       = bus.m1_read | bus.m1_write;
        // no grant while in reset, so nothing reaches the RAM or the return tag
        gnt0       = reset_n & act0 & (~act1 | ~rr_ptr_q);
        gnt1       = reset_n & act1 & (~act0 | rr_ptr_q);
        gnt        = gnt0 | gnt1;
        gnt_wr     = gnt0 ? bus.m0_write : (gnt1 & bus.m1_write);
        addr_d     = gnt0 ? bus.m0_address : gnt1 ? bus.m1_address : addr_q;
        wdata_d    = gnt0 ? bus.m0_writedata : gnt1 ? bus.m1_writedata : wdata_q;
        rr_ptr_d   = gnt ? gnt0 : rr_ptr_q;
        rtn_vld_d  = gnt & ~gnt_wr;
        rtn_id_d   = gnt1;
        conflict_d = (act0 & act1 & (conflict_q != 16'hFFFF)) ? conflict_q + 16'd1 : conflict_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= 1'b0;
            rtn_vld_q  <= 1'b0;
            rtn_id_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            conflict_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rtn_vld_q  <= rtn_vld_d;
            rtn_id_q   <= rtn_id_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.m0_waitrequest   = ~reset_n | (act0 & ~gnt0);
    assign bus.m1_waitrequest   = ~reset_n | (act1 & ~gnt1);
    assign bus.mem_chipselect   = gnt;
    assign bus.mem_write        = gnt_wr;
    assign bus.mem_clken        = reset_n;
    assign bus.mem_address      = reset_n ? addr_d : '0;
    assign bus.mem_writedata    = reset_n ? wdata_d : '0;
    assign bus.m0_readdatavalid = rtn_vld_q & ~rtn_id_q;
    assign bus.m1_readdatavalid = rtn_vld_q & rtn_id_q;
    assign bus.m0_readdata      = (rtn_vld_q & ~rtn_id_q) ? bus.mem_readdata : '0;
    assign bus.m1_readdata      = (rtn_vld_q & rtn_id_q) ? bus.mem_readdata : '0;
    assign bus.conflict_count   = conflict_q;
endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb_main_memory_arbiter: random and directed traffic against a RAM model, with a
// per-cycle comparison to a behavioural reference of the arbitration rules.
module tb_main_memory_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    main_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    main_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int vectors = 0;
    int errors = 0;

    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] ram_q = '0;
    assign bus.mem_readdata = ram_q;
    always @(posedge clk)
        if (bus.mem_chipselect && bus.mem_clken) begin
            if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
            else ram_q <= ram[bus.mem_address];
        end

    // reference state: preferred requester, pending return, last granted bus values, RAM image
    bit            m_rr = 1'b0;
    bit            m_pv = 1'b0;
    bit            m_pid = 1'b0;
    logic [DW-1:0] m_pd = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    int            m_cnt = 0;
    logic [DW-1:0] m_mem [1<<AW];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic a0, a1, w, v0, v1;
        int g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        a0 = bus.m0_read | bus.m0_write;
        a1 = bus.m1_read | bus.m1_write;
        g = (a0 && a1) ? int'(m_rr) : a0 ? 0 : a1 ? 1 : -1;
        if (!reset_n) g = -1;
        ea = (g == 0) ? bus.m0_address : (g == 1) ? bus.m1_address : m_addr;
        ed = (g == 0) ? bus.m0_writedata : (g == 1) ? bus.m1_writedata : m_wd;
        w = (g == 0) ? bus.m0_write : (g == 1) ? bus.m1_write : 1'b0;
        v0 = reset_n && m_pv && !m_pid;
        v1 = reset_n && m_pv && m_pid;
        chk("m0_waitrequest", 32'(bus.m0_waitrequest), 32'(!reset_n || (a0 && g != 0)));
        chk("m1_waitrequest", 32'(bus.m1_waitrequest), 32'(!reset_n || (a1 && g != 1)));
        chk("mem_chipselect", 32'(bus.mem_chipselect), 32'(g >= 0));
        chk("mem_write", 32'(bus.mem_write), 32'(w));
        chk("mem_clken", 32'(bus.mem_clken), 32'(reset_n));
        chk("mem_address", 32'(bus.mem_address), reset_n ? 32'(ea) : 32'd0);
        chk("mem_writedata", 32'(bus.mem_writedata), reset_n ? 32'(ed) : 32'd0);
        chk("m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(v0));
        chk("m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'(v1));
        chk("m0_readdata", 32'(bus.m0_readdata), v0 ? 32'(m_pd) : 32'd0);
        chk("m1_readdata", 32'(bus.m1_readdata), v1 ? 32'(m_pd) : 32'd0);
        chk("conflict_count", 32'(bus.conflict_count), reset_n ? 32'(m_cnt) : 32'd0);
        if (!reset_n) begin
            m_rr = 1'b0; m_pv = 1'b0; m_cnt = 0; m_addr = '0; m_wd = '0;
        end else begin
            m_pv = 1'b0;
            if (g >= 0) begin
                m_rr = (g == 0);
                m_addr = ea;
                m_wd = ed;
                if (w) m_mem[ea] = ed;
                else begin
                    m_pv = 1'b1; m_pid = (g == 1); m_pd = m_mem[ea];
                end
            end
            if (a0 && a1 && m_cnt < 65535) m_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m0_read = 1'b0; bus.m0_write = 1'b0;
        bus.m1_read = 1'b0; bus.m1_write = 1'b0;
    endtask

    task automatic rd(input bit p, input logic [AW-1:0] a);
        if (p) begin bus.m1_read = 1'b1; bus.m1_write = 1'b0; bus.m1_address = a; end
        else begin bus.m0_read = 1'b1; bus.m0_write = 1'b0; bus.m0_address = a; end
    endtask

    task automatic wr(input bit p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin bus.m1_read = 1'b0; bus.m1_write = 1'b1; bus.m1_address = a; bus.m1_writedata = d; end
        else begin bus.m0_read = 1'b0; bus.m0_write = 1'b1; bus.m0_address = a; bus.m0_writedata = d; end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = DW'(i * 37 + 11);
            m_mem[i] = DW'(i * 37 + 11);
        end
        ram[16] = 8'h5A;
        m_mem[16] = 8'h5A;
        idle();
        bus.m0_address = '0; bus.m1_address = '0;
        bus.m0_writedata = '0; bus.m1_writedata = '0;
        tick();
        rd(0, 12'h010);
        @(negedge clk);
        chk("reset_m0_waitrequest", 32'(bus.m0_waitrequest), 32'd1);
        chk("reset_mem_chipselect", 32'(bus.mem_chipselect), 32'd0);
        chk("reset_mem_clken", 32'(bus.mem_clken), 32'd0);
        chk("reset_conflict_count", 32'(bus.conflict_count), 32'd0);
        tick();
        idle();
        reset_n = 1'b1;
        rd(0, 12'h010);
        @(negedge clk);
        chk("single_m0_waitrequest", 32'(bus.m0_waitrequest), 32'd0);
        chk("single_mem_address", 32'(bus.mem_address), 32'h010);
        tick();
        idle();
        @(negedge clk);
        chk("single_m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'd1);
        chk("single_m0_readdata", 32'(bus.m0_readdata), 32'h5A);
        chk("single_m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'd0);
        tick();
        do_reset();
        rd(0, 12'h020);
        rd(1, 12'h021);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("contend_m0_waitrequest", 32'(bus.m0_waitrequest), 32'(k % 2));
            chk("contend_m1_waitrequest", 32'(bus.m1_waitrequest), 32'((k + 1) % 2));
            tick();
        end
        idle();
        @(negedge clk);
        chk("contend_conflict_count", 32'(bus.conflict_count), 32'd4);
        chk("contend_m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'd1);
        tick();
        wr(1, 12'hFFF, 8'hC3);
        tick();
        rd(1, 12'hFFF);
        tick();
        idle();
        @(negedge clk);
        chk("raw_m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'd1);
        chk("raw_m1_readdata", 32'(bus.m1_readdata), 32'hC3);
        tick();
        wr(0, 12'h100, 8'h77);
        bus.m0_read = 1'b1;
        @(negedge clk);
        chk("rw_mem_write", 32'(bus.mem_write), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("rw_m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'd0);
        tick();
        rd(0, 12'h100);
        tick();
        idle();
        @(negedge clk);
        chk("rw_m0_readdata", 32'(bus.m0_readdata), 32'h77);
        tick();
        rd(0, 12'h050);
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_m0_waitrequest", 32'(bus.m0_waitrequest), 32'd1);
        chk("midreset_mem_chipselect", 32'(bus.mem_chipselect), 32'd0);
        chk("midreset_mem_address", 32'(bus.mem_address), 32'd0);
        chk("midreset_m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'd0);
        tick();
        idle();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'd0);
        chk("release_m0_waitrequest", 32'(bus.m0_waitrequest), 32'd0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            bus.m0_read = ($urandom_range(0, 2) != 0);
            bus.m0_write = ($urandom_range(0, 2) == 0);
            bus.m1_read = ($urandom_range(0, 2) != 0);
            bus.m1_write = ($urandom_range(0, 2) == 0);
            bus.m0_address = AW'($urandom_range(0, 7)) | (($urandom_range(0, 1) != 0) ? 12'hFF8 : 12'h000);
            bus.m1_address = AW'($urandom_range(0, 7)) | (($urandom_range(0, 1) != 0) ? 12'hFF8 : 12'h000);
            bus.m0_writedata = DW'($urandom);
            bus.m1_writedata = DW'($urandom);
            if ($urandom_range(0, 4) == 0) idle();
            tick();
        end
        reset_n = 1'b1;
        idle();
        tick();
        rd(0, 12'h001);
        rd(1, 12'h002);
        repeat (70000) tick();
        @(negedge clk);
        chk("saturate_conflict_count", 32'(bus.conflict_count), 32'hFFFF);
        repeat (10) tick();
        @(negedge clk);
        chk("saturate_hold_conflict_count", 32'(bus.conflict_count), 32'hFFFF);
        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
